// File: rtl/data_mem_responder.sv
// Data-memory responder for the MEM stage: one outstanding load/store at a time,
// completed after a fixed LATENCY with a stall held towards the pipeline meanwhile.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        stall_o
);

    localparam int unsigned AW      = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  CntInit = 4'(LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic          enter_resp;
    logic          acc_we;
    logic [31:0]   acc_addr;
    logic [31:0]   acc_wdata;
    logic          acc_err;
    logic [AW-1:0] acc_idx;

    // With LATENCY==1 the access happens on the acceptance edge itself, so the
    // live request is used; otherwise the latched copy is.
    always_comb begin
        if (state_q == StIdle) begin
            acc_we    = req_we_i;
            acc_addr  = req_addr_i;
            acc_wdata = req_wdata_i;
        end else begin
            acc_we    = we_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
        end
        acc_idx = acc_addr[AW+1:2];
        acc_err = (acc_addr[1:0] != 2'b00) || (acc_addr[31:AW+2] != '0);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        enter_resp = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    we_d    = req_we_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    if (LATENCY == 1) begin
                        state_d    = StResp;
                        enter_resp = 1'b1;
                    end else begin
                        cnt_d   = CntInit;
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d    = StResp;
                    enter_resp = 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        rdata_d = '0;
        err_d   = acc_err;
        if (!acc_err && !acc_we) begin
            rdata_d = mem_q[acc_idx];
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            if (enter_resp) begin
                rdata_q <= rdata_d;
                err_q   <= err_d;
            end
        end
    end

    // Array contents survive reset; an aborted store never reaches this edge.
    always_ff @(posedge clk_i) begin
        if (enter_resp && acc_we && !acc_err) begin
            mem_q[acc_idx] <= acc_wdata;
        end
    end

    always_comb begin
        req_ready_o = (state_q == StIdle);
        rsp_valid_o = (state_q == StResp);
        rsp_rdata_o = rsp_valid_o ? rdata_q : '0;
        rsp_err_o   = rsp_valid_o & err_q;
        stall_o     = ((state_q == StIdle) & req_valid_i) | (state_q == StBusy);
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: LATENCY=3 and LATENCY=1 instances share one
// stimulus stream and are compared every cycle against a cycle-age model.
module tb_data_mem_responder;

    localparam int unsigned DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we;
    logic [31:0] req_addr, req_wdata;

    logic        ready     [2];
    logic        rsp_valid [2];
    logic        rsp_err   [2];
    logic        stall     [2];
    logic [31:0] rdata     [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(3)) u_dut3 (
        .clk_i(clk), .rst_i(rst_n), .req_valid_i(req_valid), .req_ready_o(ready[0]),
        .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid[0]), .rsp_rdata_o(rdata[0]), .rsp_err_o(rsp_err[0]),
        .stall_o(stall[0])
    );

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst_n), .req_valid_i(req_valid), .req_ready_o(ready[1]),
        .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid[1]), .rsp_rdata_o(rdata[1]), .rsp_err_o(rsp_err[1]),
        .stall_o(stall[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: age = cycles since acceptance (0 = idle); response when age == latency.
    int          lat       [2] = '{3, 1};
    int          age       [2] = '{0, 0};
    logic        m_we      [2];
    logic [31:0] m_addr    [2];
    logic [31:0] m_wdata   [2];
    logic [31:0] exp_rdata [2];
    logic        exp_err   [2];
    bit          exp_known [2];
    logic [31:0] mmem      [2][DEPTH];
    bit          written   [2][DEPTH];

    task automatic do_access(input int i);
        int idx;
        exp_err[i]   = (m_addr[i][1:0] != 2'b00) || (m_addr[i] >= 32'(4 * DEPTH));
        exp_rdata[i] = '0;
        exp_known[i] = 1'b1;
        if (!exp_err[i]) begin
            idx = int'(m_addr[i] >> 2);
            if (m_we[i]) begin
                mmem[i][idx]    = m_wdata[i];
                written[i][idx] = 1'b1;
            end else begin
                exp_rdata[i] = mmem[i][idx];
                exp_known[i] = written[i][idx];
            end
        end
    endtask

    always @(negedge rst_n) begin
        age[0] = 0;
        age[1] = 0;
    end

    always @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                if (age[i] == 0) begin
                    if (req_valid) begin
                        m_we[i]    = req_we;
                        m_addr[i]  = req_addr;
                        m_wdata[i] = req_wdata;
                        age[i]     = 1;
                        if (lat[i] == 1) do_access(i);
                    end
                end else if (age[i] == lat[i]) begin
                    age[i] = 0;
                end else begin
                    age[i] = age[i] + 1;
                    if (age[i] == lat[i]) do_access(i);
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            bit ev;
            ev = (age[i] == lat[i]);
            chk($sformatf("ready[%0d]", i), 32'(ready[i]), 32'(age[i] == 0));
            chk($sformatf("rsp_valid[%0d]", i), 32'(rsp_valid[i]), 32'(ev));
            chk($sformatf("stall[%0d]", i), 32'(stall[i]),
                32'((age[i] == 0 && req_valid) || (age[i] > 0 && age[i] < lat[i])));
            chk($sformatf("rsp_err[%0d]", i), 32'(rsp_err[i]), ev ? 32'(exp_err[i]) : 32'd0);
            if (!ev) chk($sformatf("rdata_idle[%0d]", i), rdata[i], 32'd0);
            else if (exp_known[i]) chk($sformatf("rdata[%0d]", i), rdata[i], exp_rdata[i]);
        end
    end

    // Issue one request, hold it until the LATENCY=3 instance responds.
    task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic er, output int stalls,
                          output int rdy_low, output int wait_n);
        bit got;
        got = 0; stalls = 0; rdy_low = 0; wait_n = 0; rd = '0; er = 1'b0;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (stall[0]) stalls++;
            if (!ready[0]) rdy_low++;
            if (rsp_valid[0]) begin
                rd = rdata[0]; er = rsp_err[0]; wait_n = n; got = 1;
            end
        end
        if (!got) chk("rsp_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          st, rl, wn, cnt_a, cnt_b;

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset ready", 32'(ready[0]), 32'd1);
        chk("reset rsp_valid", 32'(rsp_valid[0]), 32'd0);
        chk("reset stall", 32'(stall[0]), 32'd0);
        chk("reset rdata", rdata[0], 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_req(1'b1, 32'h10, 32'hDEADBEEF, rd, er, st, rl, wn);
        chk("st10 err", 32'(er), 32'd0);
        chk("st10 stalls", 32'(st), 32'd3);
        chk("st10 latency", 32'(wn), 32'd3);
        do_req(1'b0, 32'h10, 32'h0, rd, er, st, rl, wn);
        chk("ld10 data", rd, 32'hDEADBEEF);

        do_req(1'b1, 32'h0, 32'h1, rd, er, st, rl, wn);
        do_req(1'b1, 32'h3FC, 32'hFFFFFFFF, rd, er, st, rl, wn);
        do_req(1'b0, 32'h0, 32'h0, rd, er, st, rl, wn);
        chk("ld0 data", rd, 32'h1);
        chk("ld0 ready low", 32'(rl), 32'd3);
        do_req(1'b0, 32'h3FC, 32'h0, rd, er, st, rl, wn);
        chk("ld3fc data", rd, 32'hFFFFFFFF);

        do_req(1'b1, 32'h12, 32'h55, rd, er, st, rl, wn);
        chk("st12 err", 32'(er), 32'd1);
        chk("st12 rdata", rd, 32'd0);
        do_req(1'b0, 32'h10, 32'h0, rd, er, st, rl, wn);
        chk("ld10 after bad st", rd, 32'hDEADBEEF);

        do_req(1'b0, 32'h400, 32'h0, rd, er, st, rl, wn);
        chk("ld400 err", 32'(er), 32'd1);
        chk("ld400 rdata", rd, 32'd0);

        // Reset while the CAFE store is in BUSY.
        do_req(1'b1, 32'h20, 32'h1234, rd, er, st, rl, wn);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFE;
        @(posedge clk); #1;
        chk("busy stall", 32'(stall[0]), 32'd1);
        rst_n = 1'b0; req_valid = 1'b0;
        #1;
        chk("abort ready", 32'(ready[0]), 32'd1);
        chk("abort stall", 32'(stall[0]), 32'd0);
        chk("abort rsp_valid", 32'(rsp_valid[0]), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cnt_a = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid[0]) cnt_a++;
        end
        chk("no pulse after abort", 32'(cnt_a), 32'd0);
        @(posedge clk); #1;
        do_req(1'b0, 32'h20, 32'h0, rd, er, st, rl, wn);
        chk("ld20 after abort", rd, 32'h1234);

        // LATENCY=1 with valid held and alternating addresses.
        repeat (2) @(posedge clk);
        #1;
        cnt_a = 0; cnt_b = 0;
        for (int k = 0; k < 8; k++) begin
            req_valid = 1'b1; req_we = 1'b0;
            req_addr = (k % 2 == 0) ? 32'h0 : 32'h3FC;
            @(negedge clk);
            if (rsp_valid[1]) cnt_a++;
            if (!stall[1]) cnt_b++;
            @(posedge clk); #1;
        end
        chk("lat1 pulses", 32'(cnt_a), 32'd4);
        chk("lat1 stall low", 32'(cnt_b), 32'd4);
        req_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 99) == 0) begin
                rst_n = 1'b0; req_valid = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                rst_n = 1'b1;
            end
            req_valid = ($urandom_range(0, 9) < 7);
            req_we    = 1'($urandom_range(0, 1));
            req_wdata = $urandom;
            case ($urandom_range(0, 9))
                0: req_addr = 32'($urandom_range(0, 63)) | 32'h1;
                1: req_addr = 32'h400 + 32'($urandom_range(0, 1023) << 2);
                2: req_addr = $urandom;
                default: req_addr = 32'($urandom_range(0, 15) << 2) | 32'h3C0;
            endcase
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        repeat (6) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
